// File: rtl/fp_pkg.sv
// Shared constants, operand classes and FSM states for the binary32 multiplier.
package fp_pkg;

  localparam int FP_BIAS = 127;
  localparam int EXP_MAX = 255;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;

  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Subnormals are flushed, so exponent 0 always classifies as zero.
  function automatic fp_class_t fp_classify(input logic [31:0] x);
    fp_class_t c;
    if (x[30:23] == 8'd0) begin
      c = FP_ZERO;
    end else if (x[30:23] == 8'hFF) begin
      c = (x[22:0] != 23'd0) ? FP_NAN : FP_INF;
    end else begin
      c = FP_NORM;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp_multiplier_seq_mant.sv
// Iterative shift-add significand multiplier: one multiplier bit per cycle,
// product accumulates in the upper half while the multiplier shifts out below.
module fp_mant_mul_iter #(
  parameter int MANT_W = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [MANT_W-1:0]     mcand_i,
  input  logic [MANT_W-1:0]     mplier_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2*MANT_W-1:0]   product_o
);

  localparam int CNT_W = $clog2(MANT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MANT_W - 1);

  logic [MANT_W-1:0]   mcand_q, mcand_d;
  logic [2*MANT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [MANT_W:0]     sum_s;

  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    sum_s   = {1'b0, acc_q[2*MANT_W-1:MANT_W]} +
              (acc_q[0] ? {1'b0, mcand_q} : {(MANT_W+1){1'b0}});
    if (start_i) begin
      mcand_d = mcand_i;
      acc_d   = {{MANT_W{1'b0}}, mplier_i};
      cnt_d   = {CNT_W{1'b0}};
      busy_d  = 1'b1;
    end else if (busy_q) begin
      acc_d = {sum_s, acc_q[MANT_W-1:1]};
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q <= {MANT_W{1'b0}};
      acc_q   <= {(2*MANT_W){1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == CNT_LAST);
  assign product_o = acc_q;

endmodule

// File: rtl/fp_multiplier_seq.sv
// Multi-cycle binary32 multiplier: unpack, 24-step shift-add core, one-cycle
// normalise/RNE round, then a held result with valid/ready handshake.
module fp_multiplier_seq
  import fp_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int MANT_W = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            Exception,
  output logic            Overflow,
  output logic            Underflow
);

  localparam logic signed [9:0] EXP_OVF = 10'(EXP_MAX);
  localparam logic [9:0]        BIAS10  = 10'(FP_BIAS);

  state_t               state_q, state_d;
  logic                 start_q, start_d, sign_q, sign_d;
  logic signed [9:0]    exp_q, exp_d;
  logic [MANT_W-1:0]    mant_a_q, mant_a_d, mant_b_q, mant_b_d;
  fp_class_t            cls_a_q, cls_a_d, cls_b_q, cls_b_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic                 exc_q, exc_d, ovf_q, ovf_d, unf_q, unf_d, out_valid_q, out_valid_d;

  logic                 accept_s, core_busy_s, core_done_s;
  logic [2*MANT_W-1:0]  prod_s;
  logic [23:0]          mant_s;
  logic [24:0]          mant_r_s;
  logic [22:0]          frac_s;
  logic                 g_s, r_s, st_s, rnd_s, nan_s, inf_s, zero_s;
  logic signed [9:0]    exp1_s, exp2_s;
  logic [31:0]          res_s;
  logic                 exc_s, ovf_s, unf_s;

  fp_mant_mul_iter #(.MANT_W(MANT_W)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_q),
    .mcand_i   (mant_a_q),
    .mplier_i  (mant_b_q),
    .busy_o    (core_busy_s),
    .done_o    (core_done_s),
    .product_o (prod_s)
  );

  assign accept_s = in_valid && (state_q == S_IDLE);

  // Normalise, round to nearest even, then apply the special-case priority.
  always_comb begin
    if (prod_s[47]) begin
      mant_s = prod_s[47:24];
      g_s    = prod_s[23];
      r_s    = prod_s[22];
      st_s   = |prod_s[21:0];
      exp1_s = exp_q + 10'sd1;
    end else begin
      mant_s = prod_s[46:23];
      g_s    = prod_s[22];
      r_s    = prod_s[21];
      st_s   = |prod_s[20:0];
      exp1_s = exp_q;
    end
    rnd_s    = g_s & (r_s | st_s | mant_s[0]);
    mant_r_s = {1'b0, mant_s} + {24'd0, rnd_s};
    if (mant_r_s[24]) begin
      frac_s = mant_r_s[23:1];
      exp2_s = exp1_s + 10'sd1;
    end else begin
      frac_s = mant_r_s[22:0];
      exp2_s = exp1_s;
    end

    nan_s  = (cls_a_q == FP_NAN) || (cls_b_q == FP_NAN) ||
             ((cls_a_q == FP_INF) && (cls_b_q == FP_ZERO)) ||
             ((cls_a_q == FP_ZERO) && (cls_b_q == FP_INF));
    inf_s  = (cls_a_q == FP_INF) || (cls_b_q == FP_INF);
    zero_s = (cls_a_q == FP_ZERO) || (cls_b_q == FP_ZERO);

    res_s = 32'd0;
    exc_s = 1'b0;
    ovf_s = 1'b0;
    unf_s = 1'b0;
    if (nan_s) begin
      res_s = QNAN;
      exc_s = 1'b1;
    end else if (inf_s) begin
      res_s = {sign_q, PINF[30:0]};
      exc_s = 1'b1;
    end else if (zero_s) begin
      res_s = {sign_q, 31'd0};
    end else if (exp2_s >= EXP_OVF) begin
      res_s = {sign_q, PINF[30:0]};
      ovf_s = 1'b1;
    end else if (exp2_s <= 10'sd0) begin
      res_s = {sign_q, 31'd0};
      unf_s = 1'b1;
    end else begin
      res_s = {sign_q, exp2_s[7:0], frac_s};
    end
  end

  // Control FSM, operand unpack and result capture.
  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_a_d    = mant_a_q;
    mant_b_d    = mant_b_q;
    cls_a_d     = cls_a_q;
    cls_b_d     = cls_b_q;
    result_d    = result_q;
    exc_d       = exc_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d  = S_MUL;
          start_d  = 1'b1;
          sign_d   = A[31] ^ B[31];
          exp_d    = signed'({2'b00, A[30:23]} + {2'b00, B[30:23]} - BIAS10);
          mant_a_d = {1'b1, A[22:0]};
          mant_b_d = {1'b1, B[22:0]};
          cls_a_d  = fp_classify(A);
          cls_b_d  = fp_classify(B);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (core_done_s) begin
          state_d = S_NORM;
        end else if (!start_q && !core_busy_s) begin
          state_d = S_IDLE;   // core lost its operation: recover rather than hang
        end else begin
          state_d = S_MUL;
        end
      end
      S_NORM: begin
        state_d     = S_DONE;
        result_d    = res_s;
        exc_d       = exc_s;
        ovf_d       = ovf_s;
        unf_d       = unf_s;
        out_valid_d = 1'b1;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= 10'sd0;
      mant_a_q    <= {MANT_W{1'b0}};
      mant_b_q    <= {MANT_W{1'b0}};
      cls_a_q     <= FP_ZERO;
      cls_b_q     <= FP_ZERO;
      result_q    <= {XLEN{1'b0}};
      exc_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_a_q    <= mant_a_d;
      mant_b_q    <= mant_b_d;
      cls_a_q     <= cls_a_d;
      cls_b_q     <= cls_b_d;
      result_q    <= result_d;
      exc_q       <= exc_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign Exception = exc_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Directed bench for fp_multiplier_seq: hand-computed binary32 products,
// latency, backpressure and mid-operation reset.
module tb_fp_multiplier_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        in_ready, out_valid, Exception, Overflow, Underflow;
  logic [31:0] result;
  int          checks = 0;
  int          failures = 0;
  int          edges;

  always #5 clk = ~clk;

  fp_multiplier_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .Exception (Exception),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Flags are packed as {Exception, Overflow, Underflow}.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [2:0] exp_flags);
    int n;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, 32'd26);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_flags"}, {29'd0, Exception, Overflow, Underflow}, {29'd0, exp_flags});
    check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_flags", {29'd0, Exception, Overflow, Underflow}, 32'd0);

    run_op("mul_3x2p5", 32'h40400000, 32'h40200000, 32'h40F00000, 3'b000);
    run_op("mul_m8x2",  32'hC1000000, 32'h40000000, 32'hC1800000, 3'b000);
    run_op("rne_sticky", 32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000);
    run_op("nan_in",    32'h7FC00001, 32'h40400000, 32'h7FC00000, 3'b100);
    run_op("inf_x_0",   32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100);
    run_op("inf_x_m2",  32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b100);
    run_op("one_x_0",   32'h3F800000, 32'h00000000, 32'h00000000, 3'b000);
    run_op("overflow",  32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 3'b010);
    run_op("underflow", 32'h00800000, 32'h00800000, 32'h00000000, 3'b001);

    // Backpressure: result held while out_ready is low, stray in_valid ignored.
    A = 32'h40400000;
    B = 32'h40200000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    while (out_valid !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("bp_latency", edges, 32'd26);
    for (int i = 0; i < 10; i++) begin
      A = 32'h3F800000;
      B = 32'h40000000;
      in_valid = ~in_valid;
      @(posedge clk); #1;
      check("bp_result", result, 32'h40F00000);
      check("bp_flags", {29'd0, Exception, Overflow, Underflow}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_ready_next", {31'd0, in_ready}, 32'd1);
    check("bp_valid_drop", {31'd0, out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_ghost_op", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of MUL (core count 10) discards the operation.
    A = 32'h40400000;
    B = 32'h40200000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_result", result, 32'd0);
    check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (30) @(posedge clk);
    #1;
    check("mrst_discarded", {31'd0, out_valid}, 32'd0);
    run_op("after_rst", 32'h40400000, 32'h40200000, 32'h40F00000, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
